tick_gen: RTL
=============

# tick_gen

Parametrised multi-channel strobe generator: each of N_CH independent channels emits a one-cycle `tick` every programmable number of clock cycles, periodic or one-shot. It is the general-purpose replacement for fixed 1 Hz enable counters. Periods and modes are runtime-configurable through a single write port, and consumers (debouncers, display scanners, seconds counters) take one channel each.

## Interface
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 32, counter/period width in bits
- DEFAULT_PERIOD, 50_000_000, reset period of every channel in cycles (1 Hz at 50 MHz)
- CH_W, $clog2(N_CH) (min 1), derived channel-index width; not to be overridden

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  target channel of the write
- cfg_period  in  CNT_W  new period P in cycles, valid range 1..2^CNT_W-1
- cfg_oneshot  in  1  new mode: 0 periodic, 1 one-shot
- ch_en  in  N_CH  per-channel level enable
- ch_start  in  N_CH  per-channel start/restart pulse
- tick  out  N_CH  per-channel one-cycle strobe, registered
- ch_active  out  N_CH  channel currently counting, registered
- cfg_err  out  1  one-cycle pulse: last write rejected

## Operation
- Per channel state: period reg, mode bit, counter cnt (CNT_W), armed bit (one-shot only).
- Reset (rstn=0 at edge): period=DEFAULT_PERIOD, mode=periodic, cnt=0, armed=0; outputs tick=0, ch_active=0, cfg_err=0.
- Counting (channel active): if cnt >= period-1 then cnt<=0, tick<=1, else cnt<=cnt+1, tick<=0. The comparison is `>=`, not `==`.
- Active definition: periodic: ch_en=1; one-shot: ch_en=1 and armed=1.
- Inactive: cnt<=0, tick<=0.
- ch_en low: cnt cleared, armed cleared. No tick is generated on the disabling edge.
- ch_start, periodic mode: cnt<=0 (phase restart), tick<=0 that cycle.
- ch_start, one-shot mode with ch_en=1: armed<=1, cnt<=0. A one-shot tick clears armed in the same edge. ch_start while armed re-arms from 0.
- Config write: if cfg_ch<N_CH and cfg_period!=0, load period and mode, set cnt<=0 and armed<=0 for that channel, tick<=0.
- Rejected write (cfg_ch>=N_CH or cfg_period==0): no state change; cfg_err<=1 for one cycle.
- Priority per channel, same edge: rstn > ch_en low > cfg write > ch_start > counting.
- A cfg write together with ch_start on the same channel applies the new config, then arms (one-shot) or restarts (periodic).
- ch_active<=next-cycle active value.

## Timing
- ch_en sampled high at edges 1..P: tick high after edge P, then every P cycles thereafter.
- P=1: tick high every cycle while active.
- One-shot: ch_start at edge 0 gives exactly one tick after edge P, and ch_active falls after the same edge.
- Config write at edge k: counting restarts, and the first periodic tick occurs after edge k+P.
- cfg_err asserts the edge after the rejected write.
- The counter never exceeds period-1 and wraps to 0; there is no overflow at P=2^CNT_W-1.
- Reset mid-count: all outputs 0 the cycle after, regardless of other inputs.

## Structure
- Package tick_gen_pkg holds:
  - CNT_W and DEFAULT_PERIOD defaults
  - mode enum MODE_PERIODIC/MODE_ONESHOT
  - the priority rules as documented constants
- Sub-module tick_chan implements one channel (counter, period, mode, armed, tick, active). tick_gen decodes cfg_ch into per-channel write enables, does range/zero checks, drives cfg_err, and generates N_CH instances of tick_chan.

## Test plan
- Reset, then ch_en[0]=1 with DEFAULT_PERIOD overridden to 10 -> tick[0] after edges 10, 20, 30; other ticks stay 0.
- Write ch1 P=3 periodic, ch2 P=5 periodic, enable both -> ticks every 3 and 5 cycles, coincident at cycle 15; drop ch_en[1] at cycle 7 -> no further tick[1], cnt restart on re-enable.
- ch3 one-shot P=4, ch_start[3] -> single tick after 4 edges, ch_active[3] 1→0; re-start mid-count at cnt=2 -> tick 4 cycles after the re-start.
- Writes with cfg_period=0 and (N_CH=3) cfg_ch=3 -> cfg_err pulses one cycle each, periods unchanged, ticks undisturbed.
- Same-edge cfg write P=2 plus ch_start on a periodic channel at cnt=7 of P=9 -> tick 2 cycles later; P=1 -> tick every cycle.
- Assert rstn=0 for one cycle mid-count on all channels -> tick/ch_active/cfg_err 0 next cycle, periods back to DEFAULT_PERIOD.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
// Holds the channel mode encoding and the per-channel update priority order.
package tick_gen_pkg;

    localparam int          CNT_W_DEF          = 32;
    localparam int unsigned DEFAULT_PERIOD_DEF = 50_000_000;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // Per-channel update priority on a single edge; lower value wins.
    localparam int PRI_RESET     = 0;
    localparam int PRI_DISABLE   = 1;
    localparam int PRI_CFG_WRITE = 2;
    localparam int PRI_START     = 3;
    localparam int PRI_COUNT     = 4;

    function automatic logic chan_active(input logic en, input mode_e mode, input logic armed);
        return en && ((mode == MODE_PERIODIC) || armed);
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: period/mode registers, up-counter, one-shot arm bit,
// registered tick strobe and registered active flag.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int          CNT_W          = CNT_W_DEF,
    parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             start,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  mode_e            wr_mode,
    output logic             tick,
    output logic             active
);

    logic [CNT_W-1:0] period, period_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    mode_e            mode, mode_n;
    logic             armed, armed_n;
    logic             tick_n;
    logic             active_n;
    logic             at_last;

    assign at_last = (cnt >= (period - CNT_W'(1)));

    always_comb begin
        period_n = period;
        mode_n   = mode;
        cnt_n    = cnt;
        armed_n  = armed;
        tick_n   = 1'b0;

        // A valid write always lands in the config registers, even while the
        // channel is disabled, so channels can be set up before being enabled.
        if (wr) begin
            period_n = wr_period;
            mode_n   = wr_mode;
        end

        if (!en) begin
            cnt_n   = '0;
            armed_n = 1'b0;
        end else if (wr || start) begin
            cnt_n   = '0;
            armed_n = start && (mode_n == MODE_ONESHOT);
        end else if (chan_active(en, mode, armed)) begin
            if (at_last) begin
                cnt_n   = '0;
                tick_n  = 1'b1;
                armed_n = 1'b0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end else begin
            cnt_n = '0;
        end

        active_n = chan_active(en, mode_n, armed_n);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            period <= CNT_W'(DEFAULT_PERIOD);
            mode   <= MODE_PERIODIC;
            cnt    <= '0;
            armed  <= 1'b0;
            tick   <= 1'b0;
            active <= 1'b0;
        end else begin
            period <= period_n;
            mode   <= mode_n;
            cnt    <= cnt_n;
            armed  <= armed_n;
            tick   <= tick_n;
            active <= active_n;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable strobe generator: validates and decodes config
// writes, flags rejected writes, and instantiates one tick_chan per channel.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int          N_CH           = 4,
    parameter int          CNT_W          = CNT_W_DEF,
    parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
    parameter int          CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [N_CH-1:0]  ch_start,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  ch_active,
    output logic             cfg_err
);

    logic  cfg_ok;
    mode_e cfg_mode;

    // Channel index range matters when N_CH is not a power of two.
    assign cfg_ok   = (32'(cfg_ch) < 32'(N_CH)) && (cfg_period != '0);
    assign cfg_mode = cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic wr;
        assign wr = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));

        tick_chan #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .en        (ch_en[i]),
            .start     (ch_start[i]),
            .wr        (wr),
            .wr_period (cfg_period),
            .wr_mode   (cfg_mode),
            .tick      (tick[i]),
            .active    (ch_active[i])
        );
    end

endmodule
